uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
Frame-level controller for the UART receiver.
- Detects the start-bit falling edge and runs the per-bit oversampling edge counter and the bit counter.
- Gates the mid-bit majority sampler through its enable, and consumes its one-cycle done strobe and sampled bit.
- Deserializes 8 data bits LSB-first and checks the optional parity bit and the stop bit.
- Presents the received byte with a one-cycle valid pulse to the downstream consumer.

Parameters:
DATA_W, 8, data bits per frame (fixed frame: 1 start, DATA_W data, optional parity, 1 stop)

Ports:
CLK  input  1  oversampling clock (Prescale x baud)
RST  input  1  reset; asynchronous, active-high
RX_IN  input  1  serial line, already synchronized, idle high
Prescale  input  6  oversampling ratio; legal values 8, 16, 32; static while busy=1
PAR_EN  input  1  1 = frame carries a parity bit
PAR_TYP  input  1  0 = even, 1 = odd parity
sampled_bit  input  1  majority-voted bit from sampler
sample_done  input  1  one-cycle strobe from sampler; sampled_bit is valid in the same cycle
dat_samp_en  output  1  sampler enable
edge_cnt  output  6  oversampling edge index within the current bit, 0..Prescale-1
P_DATA  output  DATA_W  received byte
data_valid  output  1  one-cycle pulse: P_DATA holds a good frame
par_err  output  1  one-cycle pulse on parity mismatch
stp_err  output  1  one-cycle pulse on stop bit = 0
busy  output  1  1 while a frame is in progress

Behaviour:
- Reset (RST=1, asynchronous): state=IDLE; edge_cnt=0; bit counter=0; P_DATA=0; shift register=0; data_valid=0; par_err=0; stp_err=0; dat_samp_en=0; busy=0.
- FSM states: IDLE, START, DATA, PARITY, STOP. Encoding is free.
- IDLE:
  - edge_cnt held at 0; dat_samp_en=0.
  - RX_IN=0 sampled on a CLK edge -> START on the next cycle, with edge_cnt=0.
  - PAR_EN and PAR_TYP are latched on this transition and hold for the whole frame.
- Outside IDLE:
  - dat_samp_en=1 and busy=1.
  - edge_cnt increments every cycle and wraps Prescale-1 -> 0. Each wrap marks a bit boundary.
- Sampler contract: sample_done arrives at edge_cnt = Prescale/2+2 within each bit. The controller acts only on sample_done, never on a fixed edge count. A sample_done while in IDLE is ignored.
- START: on sample_done with sampled_bit=1 (glitch) -> IDLE next cycle, edge_cnt=0, no error pulse. On sampled_bit=0 -> DATA at the next wrap.
- DATA:
  - Each sample_done shifts sampled_bit in from the MSB side, giving LSB-first assembly.
  - The bit counter increments at each wrap.
  - After DATA_W bits: at the wrap go to PARITY if the latched PAR_EN=1, else STOP.
- PARITY: on sample_done, compare sampled_bit with the expected bit.
  - Expected bit = ^shift when latched PAR_TYP=0; ~^shift when PAR_TYP=1.
  - Mismatch -> par_err pulses 1 cycle (cycle after sample_done) and the frame is marked bad.
  - At the wrap -> STOP.
- STOP: on sample_done:
  - sampled_bit=0 -> stp_err pulses 1 cycle.
  - sampled_bit=1 and frame not marked bad -> P_DATA<=shift and data_valid pulses 1 cycle. Both are registered, one cycle after sample_done.
  - P_DATA is updated only on good frames and holds its value otherwise.
  - At the wrap -> IDLE with edge_cnt=0, dat_samp_en=0. A low RX_IN in that same cycle is not seen as a start; detection resumes the following cycle.
- Latency: data_valid asserts exactly one cycle after the stop-bit sample_done.
- Only one of data_valid, par_err, stp_err may be set per frame. Exception: par_err and stp_err may both pulse in the same frame, in different cycles.
- RST asserted mid-frame: everything returns to reset values immediately; the partial byte is discarded and no pulse is produced.
- Prescale changing while busy=1 is undefined and is not checked.
- Arithmetic: edge_cnt compare against Prescale-1 at 6-bit width; bit counter ceil(log2(DATA_W+1)) bits.

Test Plan:
1. Prescale=8, PAR_EN=0, send 0xA5 -> one data_valid pulse with P_DATA=0xA5, exactly 1 cycle after the stop sample_done; busy high for 10x8 cycles.
2. Prescale=16, PAR_EN=1, PAR_TYP=0, send 0x3C with parity bit 0 -> data_valid, P_DATA=0x3C, no par_err. Resend with parity bit 1 -> par_err pulses once, no data_valid, P_DATA stays 0x3C.
3. Prescale=32, PAR_EN=1, PAR_TYP=1, send 0x01 with parity 0 then with stop bit forced 0 -> first frame: data_valid, P_DATA=0x01; second frame: stp_err pulses once, no data_valid.
4. Prescale=8, drive RX_IN low for 2 cycles then high -> start sample=1, returns to IDLE, busy drops, no output pulses; a following 0x55 frame is received correctly.
5. Prescale=8, back-to-back frames 0xFF then 0x00 with no idle gap -> two data_valid pulses with P_DATA 0xFF then 0x00.
6. Prescale=16, assert RST during data bit 4 of 0x81 -> all outputs reset immediately, no data_valid. A subsequent 0x81 frame is received correctly.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// UART receiver frame controller: start detect, bit timing, LSB-first
// deserialization, parity/stop checking and one-cycle result strobes.
//
// Ports:
//   CLK, RST            oversampling clock, async active-high reset
//   RX_IN               synchronized serial line, idle high
//   Prescale            oversampling ratio (8/16/32), static while busy
//   PAR_EN, PAR_TYP     parity enable / type (0 even, 1 odd), latched at start
//   sampled_bit         majority-voted bit, valid with sample_done
//   sample_done         one-cycle strobe from the mid-bit sampler
//   dat_samp_en         sampler enable, high outside IDLE
//   edge_cnt            oversampling edge index within the current bit
//   P_DATA              last good byte received
//   data_valid          one-cycle pulse: P_DATA holds a good frame
//   par_err, stp_err    one-cycle error pulses
//   busy                high while a frame is in progress
module uart_rx_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RX_IN,
    input  logic [5:0]        Prescale,
    input  logic              PAR_EN,
    input  logic              PAR_TYP,
    input  logic              sampled_bit,
    input  logic              sample_done,
    output logic              dat_samp_en,
    output logic [5:0]        edge_cnt,
    output logic [DATA_W-1:0] P_DATA,
    output logic              data_valid,
    output logic              par_err,
    output logic              stp_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t             state, state_nxt;
    logic [5:0]         edge_nxt;
    logic [CNT_W-1:0]   bit_cnt, bit_nxt;
    logic [DATA_W-1:0]  shift, shift_nxt;
    logic [DATA_W-1:0]  pdata_nxt;
    logic               par_en_q, par_en_nxt;
    logic               par_typ_q, par_typ_nxt;
    logic               bad_q, bad_nxt;
    logic               dv_nxt, perr_nxt, serr_nxt;
    logic               wrap;
    logic               exp_par;

    assign wrap        = (edge_cnt == (Prescale - 6'd1));
    assign exp_par     = par_typ_q ? ~^shift : ^shift;
    assign busy        = (state != IDLE);
    assign dat_samp_en = (state != IDLE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            bad_q      <= 1'b0;
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            edge_cnt   <= edge_nxt;
            bit_cnt    <= bit_nxt;
            shift      <= shift_nxt;
            par_en_q   <= par_en_nxt;
            par_typ_q  <= par_typ_nxt;
            bad_q      <= bad_nxt;
            P_DATA     <= pdata_nxt;
            data_valid <= dv_nxt;
            par_err    <= perr_nxt;
            stp_err    <= serr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        edge_nxt    = edge_cnt;
        bit_nxt     = bit_cnt;
        shift_nxt   = shift;
        par_en_nxt  = par_en_q;
        par_typ_nxt = par_typ_q;
        bad_nxt     = bad_q;
        pdata_nxt   = P_DATA;
        dv_nxt      = 1'b0;
        perr_nxt    = 1'b0;
        serr_nxt    = 1'b0;

        if (state != IDLE) begin
            edge_nxt = wrap ? 6'd0 : edge_cnt + 6'd1;
        end

        unique case (state)
            IDLE: begin
                edge_nxt = '0;
                if (!RX_IN) begin
                    state_nxt   = START;
                    par_en_nxt  = PAR_EN;
                    par_typ_nxt = PAR_TYP;
                    bad_nxt     = 1'b0;
                    bit_nxt     = '0;
                end
            end
            START: begin
                // A high start sample is line noise: abort silently.
                if (sample_done && sampled_bit) begin
                    state_nxt = IDLE;
                    edge_nxt  = '0;
                end else if (wrap) begin
                    state_nxt = DATA;
                    bit_nxt   = '0;
                end
            end
            DATA: begin
                if (sample_done) begin
                    shift_nxt = {sampled_bit, shift[DATA_W-1:1]};
                end
                if (wrap) begin
                    if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                        bit_nxt   = '0;
                        state_nxt = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_nxt = bit_cnt + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (sample_done && (sampled_bit != exp_par)) begin
                    perr_nxt = 1'b1;
                    bad_nxt  = 1'b1;
                end
                if (wrap) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (sample_done) begin
                    if (!sampled_bit) begin
                        serr_nxt = 1'b1;
                    end else if (!bad_q) begin
                        pdata_nxt = shift;
                        dv_nxt    = 1'b1;
                    end
                end
                if (wrap) begin
                    state_nxt = IDLE;
                    edge_nxt  = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                edge_nxt  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: sampler model, scoreboard of
// expected result pulses, table-driven frames plus corner-case sequences.
module tb_uart_rx_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       sampled_bit = 1'b0;
    logic       sample_done = 1'b0;
    logic       dat_samp_en;
    logic [5:0] edge_cnt;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic       busy;

    uart_rx_ctrl #(.DATA_W(8)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .Prescale    (Prescale),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .sampled_bit (sampled_bit),
        .sample_done (sample_done),
        .dat_samp_en (dat_samp_en),
        .edge_cnt    (edge_cnt),
        .P_DATA      (P_DATA),
        .data_valid  (data_valid),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .busy        (busy)
    );

    always #5 CLK = ~CLK;

    // kind: 0 = data_valid, 1 = par_err, 2 = stp_err
    typedef struct {
        logic [1:0] kind;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [5:0] pre;
        logic       pen;
        logic       ptyp;
        logic [7:0] data;
        logic       pbit;
        logic       sbit;
        logic       ev;
        logic       ep;
        logic       es;
        logic [7:0] epd;
        int         ebusy;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   busy_cycles = 0;
    exp_t sb[$];
    logic bitq[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor first (sample_done still holds last cycle's value),
    // then the mid-bit sampler model for the coming cycle.
    always @(negedge CLK) begin
        logic [1:0] kind;
        exp_t       e;
        if (busy) busy_cycles++;
        if (data_valid || par_err || stp_err) begin
            kind = data_valid ? 2'd0 : (par_err ? 2'd1 : 2'd2);
            checks++;
            if (int'(data_valid) + int'(par_err) + int'(stp_err) > 1) begin
                errors++;
                $display("FAIL pulse_overlap: dv=%b pe=%b se=%b",
                         data_valid, par_err, stp_err);
            end
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: kind=%0d none expected",
                         kind);
            end else begin
                e = sb.pop_front();
                if (e.kind != kind || (kind == 2'd0 && P_DATA != e.data)) begin
                    errors++;
                    $display("FAIL pulse: kind=%0d data=%0h expected kind=%0d data=%0h",
                             kind, P_DATA, e.kind, e.data);
                end
            end
            checks++;
            if (!sample_done) begin
                errors++;
                $display("FAIL pulse_latency: got no sample_done one cycle earlier, expected 1");
            end
        end
        if (!RST && dat_samp_en && bitq.size() != 0 &&
            edge_cnt == (Prescale / 6'd2) + 6'd2) begin
            sample_done = 1'b1;
            sampled_bit = bitq.pop_front();
        end else begin
            sample_done = 1'b0;
            sampled_bit = 1'b0;
        end
    end

    // Called at a negedge. Pulls the line low until the DUT goes busy and
    // reports how many cycles that took; then flips PAR_EN/PAR_TYP so a
    // controller that fails to latch them is caught.
    task automatic send_frame(input logic [5:0] pre, input logic pen,
                              input logic ptyp, input logic [7:0] d,
                              input logic pbit, input logic sbit,
                              output int lat);
        Prescale = pre;
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        bitq.push_back(1'b0);
        for (int i = 0; i < 8; i++) bitq.push_back(d[i]);
        if (pen) bitq.push_back(pbit);
        bitq.push_back(sbit);
        RX_IN = 1'b0;
        @(negedge CLK);
        lat = 1;
        while (!busy && lat < 8) begin
            @(negedge CLK);
            lat++;
        end
        RX_IN   = 1'b1;
        PAR_EN  = ~pen;
        PAR_TYP = ~ptyp;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || bitq.size() != 0) && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL idle_timeout: still busy=%b after %0d cycles, expected 0",
                     busy, n);
        end
        repeat (2) @(negedge CLK);
    endtask

    task automatic push_exp(input logic ev, input logic ep, input logic es,
                            input logic [7:0] epd);
        exp_t e;
        if (ev) begin e.kind = 2'd0; e.data = epd;  sb.push_back(e); end
        if (ep) begin e.kind = 2'd1; e.data = 8'h0; sb.push_back(e); end
        if (es) begin e.kind = 2'd2; e.data = 8'h0; sb.push_back(e); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t tbl[7];
        int   lat;
        int   n;

        tbl[0] = '{6'd8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 80};
        tbl[1] = '{6'd16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C, 176};
        tbl[2] = '{6'd16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C, 176};
        tbl[3] = '{6'd32, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 352};
        tbl[4] = '{6'd32, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 352};
        tbl[5] = '{6'd8,  1'b1, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 88};
        tbl[6] = '{6'd8,  1'b1, 1'b1, 8'hFE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFE, 88};

        RST = 1'b1; RX_IN = 1'b1; Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_busy",   busy,        0);
        chk("rst_samp",   dat_samp_en, 0);
        chk("rst_edge",   edge_cnt,    0);
        chk("rst_pdata",  P_DATA,      0);
        chk("rst_dv",     data_valid,  0);
        chk("rst_perr",   par_err,     0);
        chk("rst_serr",   stp_err,     0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        chk("idle_edge",  edge_cnt,    0);

        foreach (tbl[i]) begin
            push_exp(tbl[i].ev, tbl[i].ep, tbl[i].es, tbl[i].epd);
            busy_cycles = 0;
            send_frame(tbl[i].pre, tbl[i].pen, tbl[i].ptyp, tbl[i].data,
                       tbl[i].pbit, tbl[i].sbit, lat);
            chk("start_lat",   lat,         1);
            wait_idle();
            chk("busy_cycles", busy_cycles, tbl[i].ebusy);
            chk("p_data",      P_DATA,      tbl[i].epd);
            chk("sb_drained",  sb.size(),   0);
        end

        // Glitch: line low two cycles, start sample reads 1.
        Prescale = 6'd8;
        busy_cycles = 0;
        bitq.push_back(1'b1);
        RX_IN = 1'b0;
        repeat (2) @(negedge CLK);
        RX_IN = 1'b1;
        wait_idle();
        chk("glitch_busy",  busy_cycles, 7);
        chk("glitch_pdata", P_DATA,      8'hFE);
        chk("glitch_edge",  edge_cnt,    0);
        push_exp(1'b1, 1'b0, 1'b0, 8'h55);
        send_frame(6'd8, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, lat);
        wait_idle();
        chk("post_glitch_pdata", P_DATA,    8'h55);
        chk("post_glitch_sb",    sb.size(), 0);

        // Back-to-back: next start driven low in the stop-bit wrap cycle.
        busy_cycles = 0;
        push_exp(1'b1, 1'b0, 1'b0, 8'hFF);
        push_exp(1'b1, 1'b0, 1'b0, 8'h00);
        send_frame(6'd8, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, lat);
        n = 0;
        while (!(bitq.size() == 0 && busy && edge_cnt == 6'd7) && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        chk("b2b_wrap_found", (n < 2000), 1);
        send_frame(6'd8, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, lat);
        chk("b2b_start_lat", lat, 2);
        wait_idle();
        chk("b2b_busy",  busy_cycles, 160);
        chk("b2b_pdata", P_DATA,      8'h00);
        chk("b2b_sb",    sb.size(),   0);

        // Reset in the middle of data bit 4.
        send_frame(6'd16, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, lat);
        n = 0;
        while (bitq.size() > 5 && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        repeat (8) @(negedge CLK);
        #1 RST = 1'b1;
        #1;
        chk("mid_rst_busy",  busy,        0);
        chk("mid_rst_samp",  dat_samp_en, 0);
        chk("mid_rst_edge",  edge_cnt,    0);
        chk("mid_rst_pdata", P_DATA,      0);
        chk("mid_rst_dv",    data_valid,  0);
        bitq.delete();
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        chk("mid_rst_sb", sb.size(), 0);
        push_exp(1'b1, 1'b0, 1'b0, 8'h81);
        send_frame(6'd16, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, lat);
        wait_idle();
        chk("post_rst_pdata", P_DATA,    8'h81);
        chk("post_rst_sb",    sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
